// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect request and the
// decode-side valid/ready channel. The fetch unit uses the master view.
interface instr_fetch_unit_if #(
   parameter int IMEM_ADDR_W = 4
);
   logic [IMEM_ADDR_W-1:0] imem_addr;
   logic [7:0]             imem_rdata;
   logic                   br_valid;
   logic [IMEM_ADDR_W-1:0] br_target;
   logic                   out_valid;
   logic [7:0]             out_instr;
   logic [IMEM_ADDR_W-1:0] out_pc;
   logic                   out_ready;
   logic                   halted;

   modport master (
      output imem_addr, out_valid, out_instr, out_pc, halted,
      input  imem_rdata, br_valid, br_target, out_ready
   );

   modport slave (
      input  imem_addr, out_valid, out_instr, out_pc, halted,
      output imem_rdata, br_valid, br_target, out_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, buffers fetched bytes in a
// 2-entry FIFO toward decode, handles redirect/flush and HALT opcode stop.
module instr_fetch_unit #(
   parameter int         IMEM_ADDR_W = 4,
   parameter logic [7:0] HALT_OP     = 8'hFF
) (
   input logic                clk,
   input logic                reset_n,
   instr_fetch_unit_if.master bus
);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_e;

   localparam logic [IMEM_ADDR_W-1:0] PC_ONE = {{(IMEM_ADDR_W-1){1'b0}}, 1'b1};

   state_e                 state_q, state_d;
   logic [IMEM_ADDR_W-1:0] pc_q, pc_d;
   logic [1:0]             count_q, count_d;
   logic [7:0]             head_instr_q, head_instr_d;
   logic [IMEM_ADDR_W-1:0] head_pc_q, head_pc_d;
   logic [7:0]             tail_instr_q, tail_instr_d;
   logic [IMEM_ADDR_W-1:0] tail_pc_q, tail_pc_d;

   logic                   pop_s;
   logic                   push_s;
   logic                   out_valid_s;
   logic [7:0]             out_instr_s;
   logic [IMEM_ADDR_W-1:0] out_pc_s;
   logic                   halted_s;

   // Handshake qualifiers; a redirect suppresses the fetch in its cycle.
   always_comb begin
      pop_s  = (count_q != 2'd0) && bus.out_ready;
      push_s = (state_q == ST_RUN) && !bus.br_valid && ((count_q < 2'd2) || pop_s);
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: redirect always returns to RUN, fetching HALT_OP stops.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (!bus.br_valid && push_s && (bus.imem_rdata == HALT_OP)) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_HALT: begin
            if (bus.br_valid) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Output logic: head entry is exposed only while valid, zero otherwise.
   always_comb begin
      out_valid_s = (count_q != 2'd0);
      halted_s    = (state_q == ST_HALT);
      if (out_valid_s) begin
         out_instr_s = head_instr_q;
         out_pc_s    = head_pc_q;
      end else begin
         out_instr_s = 8'h00;
         out_pc_s    = {IMEM_ADDR_W{1'b0}};
      end
   end

   // PC next value: redirect target, else sequential increment on fetch.
   always_comb begin
      if (bus.br_valid) begin
         pc_d = bus.br_target;
      end else if (push_s) begin
         pc_d = pc_q + PC_ONE;
      end else begin
         pc_d = pc_q;
      end
   end

   // FIFO next value; head is slot 0, a pop shifts the tail forward.
   always_comb begin
      head_instr_d = head_instr_q;
      head_pc_d    = head_pc_q;
      tail_instr_d = tail_instr_q;
      tail_pc_d    = tail_pc_q;
      count_d      = count_q;
      if (bus.br_valid) begin
         count_d = 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_instr_d = bus.imem_rdata;
                  head_pc_d    = pc_q;
               end else begin
                  tail_instr_d = bus.imem_rdata;
                  tail_pc_d    = pc_q;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_instr_d = tail_instr_q;
               head_pc_d    = tail_pc_q;
               count_d      = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  head_instr_d = bus.imem_rdata;
                  head_pc_d    = pc_q;
               end else begin
                  head_instr_d = tail_instr_q;
                  head_pc_d    = tail_pc_q;
                  tail_instr_d = bus.imem_rdata;
                  tail_pc_d    = pc_q;
               end
            end
            default: count_d = count_q;
         endcase
      end
   end

   // Datapath registers: PC, occupancy and the two buffer slots.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q         <= {IMEM_ADDR_W{1'b0}};
         count_q      <= 2'd0;
         head_instr_q <= 8'h00;
         head_pc_q    <= {IMEM_ADDR_W{1'b0}};
         tail_instr_q <= 8'h00;
         tail_pc_q    <= {IMEM_ADDR_W{1'b0}};
      end else begin
         pc_q         <= pc_d;
         count_q      <= count_d;
         head_instr_q <= head_instr_d;
         head_pc_q    <= head_pc_d;
         tail_instr_q <= tail_instr_d;
         tail_pc_q    <= tail_pc_d;
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.out_valid = out_valid_s;
   assign bus.out_instr = out_instr_s;
   assign bus.out_pc    = out_pc_s;
   assign bus.halted    = halted_s;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch front end that drives the PC into the combinational instruction memory and delivers the returned 8-bit instructions to the decode stage through a 2-entry buffer with a valid/ready handshake. The block owns the program counter and handles sequential fetch, wrap-around, consumer backpressure, branch redirect with buffer flush, and halting on a HALT opcode. It sits between the instruction memory and the decoder.

## Interface
- IMEM_ADDR_W, 4: instruction memory address width; PC width; memory holds 2^IMEM_ADDR_W bytes.
- HALT_OP, 8'hFF: opcode that stops fetching once it is buffered.

- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- imem_addr  output  IMEM_ADDR_W  address to instruction memory; equals the PC register, combinational.
- imem_rdata  input  8  instruction from memory; combinational function of imem_addr, valid in the same cycle.
- br_valid  input  1  redirect request, single-cycle pulse, sampled on the clock edge.
- br_target  input  IMEM_ADDR_W  redirect address.
- out_valid  output  1  head buffer entry is valid.
- out_instr  output  8  head entry instruction; 0 when out_valid=0.
- out_pc  output  IMEM_ADDR_W  address the head instruction was fetched from; 0 when out_valid=0.
- out_ready  input  1  decoder accepts the head entry when out_valid && out_ready.
- halted  output  1  high while in HALT state.

## Operation
- State is held in a PC register, a 2-entry FIFO of {instr, pc}, a count from 0 to 2, and a state machine with states RUN and HALT.
- pop = out_valid && out_ready.
- push = (state==RUN) && !br_valid && (count<2 || pop). On push, the FIFO writes {imem_rdata, pc} and the PC advances to pc+1 mod 2^IMEM_ADDR_W (2^IMEM_ADDR_W-1 wraps to 0).
- Push and pop in the same cycle leave count unchanged and keep FIFO order.
- State transitions:
  - RUN to HALT when a push writes imem_rdata==HALT_OP. The HALT instruction itself is delivered. The PC still increments.
  - HALT to RUN only on br_valid.
  - HALT holds the PC and does not fetch. Buffered entries still drain normally.
- Redirect (br_valid=1) has highest priority:
  - FIFO is flushed (count becomes 0), the PC loads br_target, and the state becomes RUN.
  - There is no push that cycle.
  - A pop in the same cycle counts as accepted by the decoder, and the entry is discarded from the buffer anyway.
- There is no other way to leave HALT.
- Reset (asynchronous, any time, including mid-redirect or mid-halt):
  - pc=0, count=0, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0.
  - imem_addr=0.

## Timing
- All registers update on the rising edge of clk. Reset asserts immediately and releases synchronously with the next edge's behaviour.
- Fetch-to-output latency is 1 cycle. An instruction pushed at edge N is visible at the head after edge N if the FIFO was empty.
- After reset release, the first edge pushes mem[0]. out_valid is high from that edge.
- With out_ready held high, the block sustains one instruction per cycle.
- Redirect: br_valid high in cycle T.
  - After edge T, out_valid=0 and pc=br_target.
  - After edge T+1, mem[br_target] is at the head.
- halted rises on the edge that pushes HALT_OP and falls on the edge that samples br_valid.
- When the FIFO is full and out_ready=0, imem_addr holds steady.

## Test plan
- Sequential fetch: memory holds mem[i]=8'h10+i with no HALT, out_ready=1. Release reset -> out_valid rises after the first edge, then out_instr/out_pc is 10/0, 11/1, ... 1F/15 on consecutive cycles, then 10/0 again (wrap).
- Backpressure: hold out_ready=0 for 5 cycles after the first push -> count stays at 2, imem_addr stays at 2, and out_instr stays 8'h10. Raise out_ready -> 10, 11, 12 are delivered with no loss or duplication.
- Redirect with simultaneous pop: br_valid=1, br_target=4'hA while out_valid && out_ready -> out_valid=0 for one cycle, then out_pc=A, out_instr=mem[A]. No pre-redirect entry appears afterwards.
- Halt: mem[3]=8'hFF -> instructions at 0,1,2,3 are delivered, halted=1, imem_addr holds at 4, out_valid=0 after draining. Pulse br_valid to 0 -> halted=0 and fetch restarts at 0.
- Redirect while full and halted: fill the FIFO with out_ready=0, then reach HALT, then pulse br_valid with target 7 -> flush, halted=0, head becomes pc 7 two edges after the pulse.
- Reset mid-operation: assert reset_n=0 between edges during streaming -> all outputs go to 0 immediately. After release, fetch resumes from pc 0.
